hk_spi_responder: RTL and testbench
===================================

Name: hk_spi_responder

Overview:
- SPI mode-0 slave that services the housekeeping SPI command stream (write/read/read-write streams with an 8-bit auto-incrementing address).
- Sits between the mprj_io[4:1] pad signals (SCK, CSB, SDI, SDO) and a synchronous 8-bit register file.
- SCK, CSB and SDI are oversampled in the system clock domain.
- It is the responder end of the transactions a bench host drives on the pads.

Parameters:
- SYNC_STAGES, 2, flop stages on spi_sck/spi_csb/spi_sdi before edge detection (≥2).
- ADDR_W, 8, register address width; wraps modulo 2^ADDR_W.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetb  in  1  synchronous active-low reset.
- spi_sck  in  1  SPI clock from pad, asynchronous.
- spi_csb  in  1  SPI chip select, active low, asynchronous.
- spi_sdi  in  1  SPI serial data in, MSB first.
- spi_sdo  out  1  SPI serial data out, MSB first.
- spi_sdo_oe  out  1  pad output enable for spi_sdo.
- reg_addr  out  ADDR_W  register address for the current strobe.
- reg_wdata  out  8  write data, valid with reg_we.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe; reg_rdata is valid the following cycle.
- reg_rdata  in  8  read data from the register file.
- busy  out  1  high while CSB is synchronized low.

Behaviour:
- Reset (resetb=0 at a clock edge): all outputs 0, FSM IDLE, shift registers 0, sync flops loaded with sck=0, csb=1, sdi=0.
- Edges are detected on the synchronized signals:
  - sck_rise: sync=1, previous=0.
  - sck_fall: the reverse.
  - CSB change: same scheme.
- Input-to-action latency is SYNC_STAGES+1 clocks.
- Timing constraint: SCK high and low times ≥ SYNC_STAGES+3 clock periods. Violations are undefined.
- SDI is sampled on sck_rise; SDO changes on sck_fall. A 3-bit bit counter advances on sck_rise and completes a byte at 7→0.
- FSM states:
  - IDLE: wait for CSB fall → COMMAND, bit counter cleared.
  - COMMAND: on byte complete, decode:
    - 0x80 = write stream.
    - 0x40 = read stream.
    - 0xC0 = read-write stream.
    - any other value → IGNORE.
    - Supported commands → ADDRESS.
  - ADDRESS: on byte complete, latch reg_addr → DATA. If the mode includes read, pulse reg_re at reg_addr on the next clock.
  - DATA: loops per byte until CSB rise.
  - IGNORE: no strobes, spi_sdo_oe=0, until CSB rise.
- Read path (read and read-write modes):
  - The cycle after reg_re, reg_rdata loads the tx shift register.
  - spi_sdo_oe=1; spi_sdo drives bit 7 immediately, then shifts on each subsequent sck_fall.
  - The prefetch must land before the first sck_rise of the data byte; the SCK timing constraint guarantees this.
- Byte complete in DATA:
  - Write / read-write: reg_we pulses with reg_addr = current address and reg_wdata = the received byte.
  - Next cycle: reg_addr increments by 1 (0xFF→0x00 wrap).
  - Read modes: reg_re pulses at the new address the cycle after the increment.
  - Read-only mode: reg_wdata is don't-care, and reg_we never asserts.
- Same cycle: reg_we and reg_re are never high together.
- CSB rise at any point: abort to IDLE within SYNC_STAGES+1 clocks.
  - Partial byte discarded, no strobe for it.
  - spi_sdo_oe=0, spi_sdo=0, busy=0.
  - reg_addr holds its last value.
- CSB fall while already non-IDLE (glitch after a rise not yet seen): impossible by the edge-detect order. A rise is always processed first.
- SCK edges while CSB is high are ignored.
- Reset mid-transfer: immediate return to reset state. Transfer resumes only after a fresh CSB fall.

Decomposition:
- Package hk_spi_pkg holds:
  - the state enum (IDLE, COMMAND, ADDRESS, DATA, IGNORE);
  - command constants CMD_WRITE=8'h80, CMD_READ=8'h40, CMD_RDWR=8'hC0;
  - the mode enum (WR, RD, RW).
- One sub-module: hk_spi_sync_edge. It holds a SYNC_STAGES synchronizer plus a previous-value flop per input and outputs the level, rise and fall. It is instanced for sck, csb and sdi (level only).

Test Plan:
- Register stub with reg3=0x11. Host sends 0x40, 0x03, then reads 1 byte → reg_re at addr 0x03 once; SDO byte = 0x11; spi_sdo_oe drops after CSB rise.
- Host sends 0x80, 0x0b, 0x01, then CSB high; then 0x80, 0x0b, 0x00 → exactly two reg_we pulses at addr 0x0b with data 0x01 then 0x00; no reg_re.
- Stub loaded with 0x00, 0x04, 0x56, 0x11, 0x00 ×4, 0x02, 0x01, 0x00 ×3, 0xff, 0xef, 0xff, 0x03, 0x12, 0x04. Host sends 0x40, 0x00 and reads 19 bytes → reg_re addresses 0..18 in order (reg_re for addr 19 during the final byte is accepted); SDO bytes match the stub values.
- Host sends 0xC0, 0xFF, then 2 bytes 0xA5, 0x5A → reg_we (0xFF, 0xA5), then (0x00, 0x5A); reads return the stub's pre-write values for 0xFF and 0x00 (address wrap verified).
- Host sends 0x80, 0x10, then 4 bits of 0xC3 and raises CSB → no reg_we; busy=0 within SYNC_STAGES+1 clocks. Next transaction 0x20, 0x00, 0x00 → IGNORE: no strobes, spi_sdo_oe stays 0.
- resetb low for 1 clock during the third data byte of a read stream → all outputs 0 the next cycle. A new 0x40, 0x03 transaction then returns 0x11 correctly.

Source files
------------

// File: rtl/hk_spi_pkg.sv
// Shared types and constants for the housekeeping SPI responder.
// States, transfer modes and the command bytes that select them.
package hk_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        ADDRESS,
        DATA,
        IGNORE
    } state_e;

    typedef enum logic [1:0] {
        WR,
        RD,
        RW
    } mode_e;

    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h40;
    localparam logic [7:0] CMD_RDWR  = 8'hC0;

    function automatic logic mode_reads(input mode_e m);
        return (m != WR);
    endfunction

endpackage

// File: rtl/hk_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pad input.
// Provides the synchronized level plus single-cycle rise/fall pulses.
module hk_spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/hk_spi_responder.sv
// SPI mode-0 responder for the housekeeping command stream, bridging the
// oversampled pad signals to a synchronous 8-bit register file.
module hk_spi_responder
    import hk_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              spi_sck,
    input  logic              spi_csb,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    logic sck_lvl, sck_rise, sck_fall;
    logic csb_lvl, csb_rise, csb_fall;
    logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

    hk_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clk(clock), .resetb(resetb), .d_i(spi_sck),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    hk_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csb (
        .clk(clock), .resetb(resetb), .d_i(spi_csb),
        .level_o(csb_lvl), .rise_o(csb_rise), .fall_o(csb_fall)
    );
    hk_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
        .clk(clock), .resetb(resetb), .d_i(spi_sdi),
        .level_o(sdi_lvl), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              inc_q, inc_d;
    logic              rdreq_q, rdreq_d;
    logic              load_q, load_d;
    logic              oe_q, oe_d;

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       sck_unused;

    assign rx_byte    = {rx_q[6:0], sdi_lvl};
    assign byte_done  = sck_rise && (bit_cnt_q == 3'd7);
    assign sck_unused = sck_lvl;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        inc_d     = 1'b0;
        rdreq_d   = 1'b0;
        load_d    = 1'b0;
        oe_d      = oe_q;

        if (state_q != IDLE) begin
            if (sck_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            // The fall right after a byte boundary must not shift away the freshly loaded MSB.
            if (sck_fall && (state_q == DATA) && (bit_cnt_q != 3'd0))
                tx_d = {tx_q[6:0], 1'b0};
        end

        // Post-byte pipeline: increment, read strobe, then capture of the read data.
        if (inc_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            rdreq_d = mode_reads(mode_q);
        end
        if (rdreq_q) re_d = 1'b1;
        if (re_q) load_d = 1'b1;
        if (load_q) begin
            tx_d = reg_rdata;
            oe_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d   = COMMAND;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                end
            end
            COMMAND: begin
                if (byte_done) begin
                    case (rx_byte)
                        CMD_WRITE: begin mode_d = WR; state_d = ADDRESS; end
                        CMD_READ:  begin mode_d = RD; state_d = ADDRESS; end
                        CMD_RDWR:  begin mode_d = RW; state_d = ADDRESS; end
                        default:   state_d = IGNORE;
                    endcase
                end
            end
            ADDRESS: begin
                if (byte_done) begin
                    addr_d  = ADDR_W'(rx_byte);
                    state_d = DATA;
                    re_d    = mode_reads(mode_q);
                end
            end
            DATA: begin
                if (byte_done) begin
                    if (mode_q != RD) begin
                        we_d    = 1'b1;
                        wdata_d = rx_byte;
                    end
                    inc_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (csb_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
            oe_d      = 1'b0;
            we_d      = 1'b0;
            re_d      = 1'b0;
            inc_d     = 1'b0;
            rdreq_d   = 1'b0;
            load_d    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q   <= IDLE;
            mode_q    <= WR;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            inc_q     <= 1'b0;
            rdreq_q   <= 1'b0;
            load_q    <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            inc_q     <= inc_d;
            rdreq_q   <= rdreq_d;
            load_q    <= load_d;
            oe_q      <= oe_d;
        end
    end

    assign spi_sdo    = oe_q & tx_q[7];
    assign spi_sdo_oe = oe_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;
    assign busy       = ~csb_lvl;

endmodule

// File: tb/tb_hk_spi_responder.sv
// Directed bench: a bit-banged SPI host on the pads and a registered-read
// register stub; strobes are logged and compared against hand-derived values.
module tb_hk_spi_responder;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_csb = 1'b1;
    logic       spi_sdi = 1'b0;
    logic       spi_sdo, spi_sdo_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [256];
    logic [7:0] we_addr_log[$];
    logic [7:0] we_data_log[$];
    logic [7:0] re_addr_log[$];
    int         both_cnt = 0;
    logic       oe_seen = 1'b0;

    logic [7:0] t3_exp [0:18] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hff,
                                  8'hef, 8'hff, 8'h03, 8'h12, 8'h04};

    always #5 clock = ~clock;

    hk_spi_responder #(.SYNC_STAGES(SYNC), .ADDR_W(8)) dut (
        .clock(clock), .resetb(resetb),
        .spi_sck(spi_sck), .spi_csb(spi_csb), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .busy(busy)
    );

    // Register file stub with one-cycle registered read.
    always @(posedge clock) begin
        if (reg_we) mem[reg_addr] = reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clock) begin
        if (resetb) begin
            if (reg_we) begin
                we_addr_log.push_back(reg_addr);
                we_data_log.push_back(reg_wdata);
            end
            if (reg_re) re_addr_log.push_back(reg_addr);
            if (reg_we && reg_re) both_cnt++;
            if (spi_sdo_oe) oe_seen = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        we_addr_log.delete();
        we_data_log.delete();
        re_addr_log.delete();
        oe_seen = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sdi = tx[i];
            repeat (HALF) @(negedge clock);
            rx[i] = spi_sdo;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_start();
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clock);
        spi_csb = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    initial begin
        logic [7:0] rx;
        int         lat;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 19; i++) mem[i] = t3_exp[i];
        mem[8'hFF] = 8'h3C;

        repeat (3) @(negedge clock);
        check("reset_outputs", {spi_sdo, spi_sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, busy}, 32'h0);
        resetb = 1'b1;
        repeat (4) @(negedge clock);

        // Single-byte read of reg 3.
        clear_logs();
        cs_start();
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("t1_oe_during", spi_sdo_oe, 1);
        check("t1_busy_during", busy, 1);
        cs_end();
        $display("txn t1 read addr 03 -> %02h", rx);
        check("t1_rdata", rx, 8'h11);
        check("t1_re_first", re_addr_log.size() > 0 ? re_addr_log[0] : 8'hxx, 8'h03);
        check("t1_re_addr3_cnt", re_addr_log.size() >= 1 && (re_addr_log.size() < 2 || re_addr_log[1] != 8'h03), 1);
        check("t1_we_cnt", we_addr_log.size(), 0);
        check("t1_oe_after", {spi_sdo_oe, spi_sdo, busy}, 0);
        check("t1_addr_hold", reg_addr, 8'h04);

        // Two separate single-byte writes to 0x0b.
        clear_logs();
        cs_start(); spi_bits(8'h80, 8, rx); spi_bits(8'h0b, 8, rx); spi_bits(8'h01, 8, rx); cs_end();
        cs_start(); spi_bits(8'h80, 8, rx); spi_bits(8'h0b, 8, rx); spi_bits(8'h00, 8, rx); cs_end();
        $display("txn t2 write 0b <- 01, 0b <- 00 (we count %0d)", we_addr_log.size());
        check("t2_we_cnt", we_addr_log.size(), 2);
        if (we_addr_log.size() == 2) begin
            check("t2_we0_addr", we_addr_log[0], 8'h0b);
            check("t2_we0_data", we_data_log[0], 8'h01);
            check("t2_we1_addr", we_addr_log[1], 8'h0b);
            check("t2_we1_data", we_data_log[1], 8'h00);
        end
        check("t2_re_cnt", re_addr_log.size(), 0);
        check("t2_oe_seen", oe_seen, 0);

        // 19-byte read stream from 0.
        clear_logs();
        cs_start();
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h00, 8, rx);
        for (int i = 0; i < 19; i++) begin
            spi_bits(8'h00, 8, rx);
            $display("txn t3 read byte %0d -> %02h", i, rx);
            check($sformatf("t3_rdata_%0d", i), rx, t3_exp[i]);
        end
        cs_end();
        check("t3_re_cnt_ok", re_addr_log.size() == 19 || re_addr_log.size() == 20, 1);
        for (int i = 0; i < 19; i++)
            if (i < re_addr_log.size())
                check($sformatf("t3_re_addr_%0d", i), re_addr_log[i], i);
        check("t3_we_cnt", we_addr_log.size(), 0);

        // Read-write stream wrapping 0xFF -> 0x00.
        clear_logs();
        cs_start();
        spi_bits(8'hC0, 8, rx);
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'hA5, 8, rx);
        $display("txn t4 rw addr ff <- a5, read %02h", rx);
        check("t4_rd_ff", rx, 8'h3C);
        spi_bits(8'h5A, 8, rx);
        $display("txn t4 rw addr 00 <- 5a, read %02h", rx);
        check("t4_rd_00", rx, 8'h00);
        cs_end();
        check("t4_we_cnt", we_addr_log.size(), 2);
        if (we_addr_log.size() == 2) begin
            check("t4_we0", {we_addr_log[0], we_data_log[0]}, 16'hFFA5);
            check("t4_we1", {we_addr_log[1], we_data_log[1]}, 16'h005A);
        end
        check("t4_re_ok", re_addr_log.size() >= 2, 1);
        if (re_addr_log.size() >= 2) check("t4_re01", {re_addr_log[0], re_addr_log[1]}, 16'hFF00);
        check("t4_mem", {mem[8'hFF], mem[8'h00]}, 16'hA55A);

        // Aborted partial byte, then an unsupported command.
        clear_logs();
        cs_start();
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h10, 8, rx);
        spi_bits(8'hC3, 4, rx);
        repeat (HALF) @(negedge clock);
        spi_csb = 1'b1;
        lat = 0;
        while (busy && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        $display("txn t5 abort after 4 bits, busy dropped after %0d clocks", lat);
        check("t5_busy_lat_ok", lat <= SYNC + 1, 1);
        repeat (12) @(negedge clock);
        check("t5_we_cnt", we_addr_log.size(), 0);
        check("t5_re_cnt", re_addr_log.size(), 0);
        clear_logs();
        cs_start(); spi_bits(8'h20, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h00, 8, rx); cs_end();
        $display("txn t5 ignored command 20");
        check("t5_ign_strobes", we_addr_log.size() + re_addr_log.size(), 0);
        check("t5_ign_oe", oe_seen, 0);

        // Reset pulse in the middle of the third data byte of a read stream.
        cs_start();
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h05, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 3, rx);
        check("t6_busy_before", busy, 1);
        resetb = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        check("t6_reset_outputs", {spi_sdo, spi_sdo_oe, reg_addr, reg_wdata, reg_we, reg_re, busy}, 32'h0);
        spi_csb = 1'b1;
        repeat (12) @(negedge clock);
        cs_start();
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_end();
        $display("txn t6 read after reset addr 03 -> %02h", rx);
        check("t6_rdata", rx, 8'h11);

        check("no_we_re_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
